// File: rtl/axi_bm13xx_regs.sv
// axi_bm13xx_regs: AXI4-Lite register block for a BM13xx ASIC interface.
// Holds control registers, exposes status and bridges the CMD/WORK FIFOs.
module axi_bm13xx_regs #(
  parameter logic [31:0] VERSION  = 32'h0001_0100,
  parameter logic [31:0] BUILD_ID = 32'h0
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_aresetn,
  input  logic [15:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [15:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [3:0]  ctrl_o,
  output logic        err_clr_o,
  output logic [11:0] baud_o,
  output logic [23:0] work_time_o,
  output logic [2:0]  irq_en_o,
  output logic [3:0]  fifo_rst_o,
  input  logic [14:0] stat_i,
  input  logic [31:0] err_cnt_i,
  input  logic [63:0] rx_data_i,
  output logic [1:0]  rx_pop_o,
  output logic [31:0] tx_data_o,
  output logic [1:0]  tx_push_o
);
  typedef enum logic {W_IDLE, W_RESP} wr_st_t;
  typedef enum logic {R_IDLE, R_DATA} rd_st_t;
  localparam logic [15:0] A_VER = 16'h0000, A_BLD = 16'h0004, A_CTRL = 16'h0008, A_STAT = 16'h000C;
  localparam logic [15:0] A_BAUD = 16'h0010, A_WTIME = 16'h0014, A_ERR = 16'h0018;
  localparam logic [15:0] A_CRX = 16'h1000, A_CTX = 16'h1004, A_CCTL = 16'h1008, A_CST = 16'h100C;
  localparam logic [15:0] A_WRX = 16'h2000, A_WRCTL = 16'h2008, A_WRST = 16'h200C;
  localparam logic [15:0] A_WTX = 16'h3004, A_WTCTL = 16'h3008, A_WTST = 16'h300C;

  wr_st_t      r_wst, w_wst_nxt;
  rd_st_t      r_rst, w_rst_nxt;
  logic        r_aw_got, r_w_got;
  logic [13:0] r_awaddr;
  logic [31:0] r_wdata;
  logic [3:0]  r_ctrl;
  logic        r_err_clr;
  logic [11:0] r_baud;
  logic [23:0] r_work_time;
  logic [2:0]  r_irq_en;
  logic [3:0]  r_fifo_rst;
  logic [1:0]  r_tx_push, r_rx_pop;
  logic [31:0] r_tx_data, r_rdata;
  logic [1:0]  r_bresp, r_rresp;
  logic        w_aw_hs, w_w_hs, w_wdo, w_rdo, w_werr, w_rerr, w_unused;
  logic [13:0] w_waddr;
  logic [15:0] w_wa, w_ra;
  logic [31:0] w_wdat, w_rd;
  logic [1:0]  w_push, w_pop;

  assign w_unused  = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};
  assign w_aw_hs   = s_axi_awvalid && s_axi_awready;
  assign w_w_hs    = s_axi_wvalid && s_axi_wready;
  assign w_waddr   = r_aw_got ? r_awaddr : s_axi_awaddr[15:2];
  assign w_wdat    = r_w_got ? r_wdata : s_axi_wdata;
  assign w_wa      = {w_waddr, 2'b00};
  assign w_ra      = {s_axi_araddr[15:2], 2'b00};
  // The write executes on the edge where the later of AW/W is accepted.
  assign w_wdo     = r_wst == W_IDLE && (r_aw_got || w_aw_hs) && (r_w_got || w_w_hs);
  assign w_rdo     = r_rst == R_IDLE && s_axi_arvalid;

  assign ctrl_o      = r_ctrl;
  assign err_clr_o   = r_err_clr;
  assign baud_o      = r_baud;
  assign work_time_o = r_work_time;
  assign irq_en_o    = r_irq_en;
  assign fifo_rst_o  = r_fifo_rst;
  assign tx_push_o   = r_tx_push;
  assign tx_data_o   = r_tx_data;
  assign rx_pop_o    = r_rx_pop;
  assign s_axi_bresp = r_bresp;
  assign s_axi_rdata = r_rdata;
  assign s_axi_rresp = r_rresp;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
    if (!s_axi_aresetn) begin
      r_wst <= W_IDLE;
      r_rst <= R_IDLE;
    end else begin
      r_wst <= w_wst_nxt;
      r_rst <= w_rst_nxt;
    end

  always_comb begin
    w_wst_nxt = r_wst == W_IDLE ? (w_wdo ? W_RESP : W_IDLE) : (s_axi_bready ? W_IDLE : W_RESP);
    w_rst_nxt = r_rst == R_IDLE ? (w_rdo ? R_DATA : R_IDLE) : (s_axi_rready ? R_IDLE : R_DATA);
  end

  always_comb begin
    s_axi_awready = r_wst == W_IDLE && !r_aw_got;
    s_axi_wready  = r_wst == W_IDLE && !r_w_got;
    s_axi_bvalid  = r_wst == W_RESP;
    s_axi_arready = r_rst == R_IDLE;
    s_axi_rvalid  = r_rst == R_DATA;
  end

  always_comb begin
    w_werr = 1'b0;
    w_push = '0;
    case (w_wa)
      A_CTRL, A_BAUD, A_WTIME, A_CCTL, A_WRCTL, A_WTCTL: w_werr = 1'b0;
      A_CTX: begin
        w_werr    = stat_i[3];
        w_push[0] = !stat_i[3];
      end
      A_WTX: begin
        w_werr    = stat_i[13];
        w_push[1] = !stat_i[13];
      end
      default: w_werr = 1'b1;
    endcase
  end

  always_comb begin
    w_rd   = '0;
    w_rerr = 1'b0;
    w_pop  = '0;
    case (w_ra)
      A_VER:   w_rd = VERSION;
      A_BLD:   w_rd = BUILD_ID;
      A_CTRL:  w_rd = {27'b0, r_ctrl, 1'b0};
      A_STAT:  w_rd = '0;
      A_BAUD:  w_rd = {20'b0, r_baud};
      A_WTIME: w_rd = {8'b0, r_work_time};
      A_ERR:   w_rd = err_cnt_i;
      A_CRX: begin
        w_rerr   = stat_i[0];
        w_pop[0] = !stat_i[0];
        w_rd     = stat_i[0] ? '0 : rx_data_i[31:0];
      end
      A_CCTL:  w_rd = {29'b0, r_irq_en[0], 2'b00};
      A_CST:   w_rd = {27'b0, stat_i[4:0]};
      A_WRX: begin
        w_rerr   = stat_i[5];
        w_pop[1] = !stat_i[5];
        w_rd     = stat_i[5] ? '0 : rx_data_i[63:32];
      end
      A_WRCTL: w_rd = {29'b0, r_irq_en[1], 2'b00};
      A_WRST:  w_rd = {27'b0, stat_i[9:5]};
      A_WTCTL: w_rd = {29'b0, r_irq_en[2], 2'b00};
      A_WTST:  w_rd = {27'b0, stat_i[14:10]};
      default: w_rerr = 1'b1;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
    if (!s_axi_aresetn) begin
      r_aw_got    <= 1'b0;
      r_w_got     <= 1'b0;
      r_awaddr    <= '0;
      r_wdata     <= '0;
      r_ctrl      <= '0;
      r_err_clr   <= 1'b0;
      r_baud      <= '0;
      r_work_time <= '0;
      r_irq_en    <= '0;
      r_fifo_rst  <= '0;
      r_tx_push   <= '0;
      r_tx_data   <= '0;
      r_bresp     <= '0;
      r_rx_pop    <= '0;
      r_rdata     <= '0;
      r_rresp     <= '0;
    end else begin
      r_aw_got   <= !w_wdo && (r_aw_got || w_aw_hs);
      r_w_got    <= !w_wdo && (r_w_got || w_w_hs);
      if (w_aw_hs) r_awaddr <= s_axi_awaddr[15:2];
      if (w_w_hs) r_wdata <= s_axi_wdata;
      r_err_clr  <= w_wdo && w_wa == A_CTRL && w_wdat[0];
      r_fifo_rst <= w_wdo ? {w_wa == A_WTCTL && w_wdat[1], w_wa == A_WRCTL && w_wdat[0],
                             w_wa == A_CCTL && w_wdat[1], w_wa == A_CCTL && w_wdat[0]} : 4'b0;
      r_tx_push  <= w_wdo ? w_push : 2'b0;
      if (w_wdo) begin
        if (w_wa == A_CTRL) r_ctrl <= w_wdat[4:1];
        if (w_wa == A_BAUD) r_baud <= w_wdat[11:0];
        if (w_wa == A_WTIME) r_work_time <= w_wdat[23:0];
        if (w_wa == A_CCTL) r_irq_en[0] <= w_wdat[2];
        if (w_wa == A_WRCTL) r_irq_en[1] <= w_wdat[2];
        if (w_wa == A_WTCTL) r_irq_en[2] <= w_wdat[2];
        if (|w_push) r_tx_data <= w_wdat;
        r_bresp <= w_werr ? 2'b10 : 2'b00;
      end
      r_rx_pop <= w_rdo ? w_pop : 2'b0;
      if (w_rdo) begin
        r_rdata <= w_rd;
        r_rresp <= w_rerr ? 2'b10 : 2'b00;
      end
    end
endmodule

// File: doc/axi_bm13xx_regs.md
AXI_BM13XX_REGS -- requirements
Module: axi_bm13xx_regs

Interface
REQ-001 SHALL have parameter VERSION, default 32'h0001_0100, value returned at offset 0x0000.
REQ-002 SHALL have parameter BUILD_ID, default 32'h0, value returned at offset 0x0004.
REQ-003 SHALL have port s_axi_aclk  input  1  sole clock, all logic rising-edge.
REQ-004 SHALL have port s_axi_aresetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port s_axi_awaddr  input  16  write address.
REQ-006 SHALL have port s_axi_awvalid  input  1  write address valid.
REQ-007 SHALL have port s_axi_awready  output  1  write address ready.
REQ-008 SHALL have port s_axi_wdata  input  32  write data; full-word writes only, no strobes.
REQ-009 SHALL have port s_axi_wvalid  input  1  write data valid.
REQ-010 SHALL have port s_axi_wready  output  1  write data ready.
REQ-011 SHALL have port s_axi_bresp  output  2  write response, OKAY=00, SLVERR=10.
REQ-012 SHALL have port s_axi_bvalid  output  1  write response valid.
REQ-013 SHALL have port s_axi_bready  input  1  write response ready.
REQ-014 SHALL have port s_axi_araddr  input  16  read address.
REQ-015 SHALL have port s_axi_arvalid  input  1  read address valid.
REQ-016 SHALL have port s_axi_arready  output  1  read address ready.
REQ-017 SHALL have port s_axi_rdata  output  32  read data.
REQ-018 SHALL have port s_axi_rresp  output  2  read response.
REQ-019 SHALL have port s_axi_rvalid  output  1  read data valid.
REQ-020 SHALL have port s_axi_rready  input  1  read data ready.
REQ-021 SHALL have port ctrl_o  output  4  {bm139x, enable, midstate[1:0]} = CTRL_REG[4:1].
REQ-022 SHALL have port err_clr_o  output  1  one-cycle error-counter clear pulse.
REQ-023 SHALL have port baud_o  output  12  baud divisor = BAUD_REG[11:0].
REQ-024 SHALL have port work_time_o  output  24  work delay = WORK_TIME[23:0].
REQ-025 SHALL have port irq_en_o  output  3  {work_tx, work_rx, cmd} interrupt enables.
REQ-026 SHALL have port fifo_rst_o  output  4  one-cycle pulses {work_tx, work_rx, cmd_tx, cmd_rx}.
REQ-027 SHALL have port stat_i  input  15  {work_tx[14:10], work_rx[9:5], cmd[4:0]}, each {irq_pend, tx_full, tx_empty, rx_full, rx_empty}.
REQ-028 SHALL have port err_cnt_i  input  32  error counter value.
REQ-029 SHALL have port rx_data_i  input  64  {work_rx, cmd_rx} FIFO heads, first-word-fall-through.
REQ-030 SHALL have port rx_pop_o  output  2  {work_rx, cmd_rx} one-cycle pop strobes.
REQ-031 SHALL have port tx_data_o  output  32  push data, shared by both TX FIFOs.
REQ-032 SHALL have port tx_push_o  output  2  {work_tx, cmd_tx} one-cycle push strobes.

Function
REQ-033 SHALL decode s_axi_*addr[15:2], ignore [1:0]; map: 0x0000 VERSION, 0x0004 BUILD_ID, 0x0008 CTRL, 0x000C STAT (reads 0), 0x0010 BAUD, 0x0014 WORK_TIME, 0x0018 ERR_COUNTER, 0x1000/0x1004/0x1008/0x100C CMD RX/TX/CTRL/STAT, 0x2000/0x2008/0x200C WORK_RX FIFO/CTRL/STAT, 0x3004/0x3008/0x300C WORK_TX FIFO/CTRL/STAT; all other offsets unmapped.
REQ-034 SHALL run the write FSM IDLE->RESP: awready/wready high in IDLE until each is captured (either order, or same cycle); the write takes effect in the cycle both are held; bvalid asserts the next cycle and holds until bready; both readies are low in RESP.
REQ-035 SHALL run the read FSM IDLE->DATA: arready high only in IDLE; rdata/rresp are registered at the AR handshake, rvalid asserts the next cycle and is held stable until rready.
REQ-036 SHALL apply CTRL writes: bits[4:1] stored; bit0 produces err_clr_o pulse; reads return {27'b0, stored[4:1], 1'b0}.
REQ-037 SHALL apply CTRL writes to CMD/WORK_RX/WORK_TX registers: bit2 stored as irq_en; bit1 pulses the TX reset (CMD, WORK_TX only); bit0 pulses the RX reset (CMD, WORK_RX only); reads return only bit2.
REQ-038 SHALL push a TX FIFO write with tx_data_o=wdata for one cycle; if the target full bit (stat_i[3] or stat_i[13]) is set, it SHALL suppress the push and respond SLVERR.
REQ-039 SHALL pop an RX FIFO read at the AR handshake, capturing the head word; if the empty bit (stat_i[0] or stat_i[5]) is set, it SHALL suppress the pop and return 0 with SLVERR.
REQ-040 SHALL answer unmapped or wrong-direction accesses with SLVERR, read data 0, and no side effects.
REQ-041 SHALL treat read and write channels independently; a same-cycle read of a register being written returns the old value.

Reset
REQ-042 SHALL on s_axi_aresetn low asynchronously clear all outputs, stored registers and strobes to 0, and return both FSMs to IDLE; an in-flight transaction is discarded.

Verification
REQ-043 SHALL check: write CTRL=0x1B -> err_clr_o pulses 1 cycle; ctrl_o=4'hD; CTRL readback 0x1A, OKAY.
REQ-044 SHALL check: wvalid 3 cycles before awvalid to CMD_TX_FIFO, data 0xDEADBEEF -> one tx_push_o[0] pulse with tx_data_o=0xDEADBEEF, bvalid held until delayed bready.
REQ-045 SHALL check: read WORK_RX_FIFO with head 0x12345678 -> rdata 0x12345678, one rx_pop_o[1] pulse; with stat_i[5]=1 -> no pop, rdata 0, SLVERR.
REQ-046 SHALL check: write 0x7 to WORK_TX_CTRL -> fifo_rst_o=4'b1000 for one cycle, irq_en_o[2]=1, readback 0x4.
REQ-047 SHALL check: read 0x0020 -> SLVERR, 0; write CMD_TX_FIFO with stat_i[3]=1 -> no push, SLVERR; reset asserted during RESP -> bvalid 0 immediately.
